imem_sync: RTL and testbench
============================

IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter FILL_WORD, default all ones of DATA_W, the init and error word.
REQ-005 SHALL have port clk, input, 1, the single clock; all state rises on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port fetch_req, input, 1, fetch request.
REQ-008 SHALL have port fetch_addr, input, ADDR_W, fetch byte address.
REQ-009 SHALL have port fetch_stall, input, 1, consumer stall; holds the output word.
REQ-010 SHALL have port fetch_ready, output, 1, a request is accepted this cycle.
REQ-011 SHALL have port fetch_valid, output, 1, fetch_word is valid.
REQ-012 SHALL have port fetch_word, output, DATA_W, the fetched instruction.
REQ-013 SHALL have port fetch_err, output, 1, the fetch was misaligned or out of range.
REQ-014 SHALL have port ld_en, input, 1, program-load write strobe.
REQ-015 SHALL have port ld_addr, input, ADDR_W, load byte address.
REQ-016 SHALL have port ld_data, input, DATA_W, load word.
REQ-017 SHALL have port ld_ack, output, 1, one-cycle pulse when a load is committed.
REQ-018 SHALL have port init_done, output, 1, memory fill is complete.
REQ-019 SHALL have port parity_err, output, 1, a stored-word parity mismatch was seen on fetch.

Function
REQ-020 SHALL implement a two-state FSM: INIT, then RUN.
- INIT writes FILL_WORD to word 0..DEPTH-1, one word per cycle, using a counter.
- After word DEPTH-1 is written, the next state is RUN.
- Result: RUN and init_done=1 exactly DEPTH cycles after rst deasserts.
REQ-021 In INIT, fetch_ready=0, fetch_valid=0, and ld_en SHALL be ignored with no ld_ack.
REQ-022 In RUN, fetch_ready SHALL equal NOT(fetch_valid AND fetch_stall).
REQ-023 A request is accepted when fetch_req AND fetch_ready; on the next cycle fetch_valid=1 and fetch_word=mem[fetch_addr[log2(DEPTH)+1:2]] (1-cycle latency).
REQ-024 While fetch_valid AND fetch_stall, fetch_word, fetch_err and fetch_valid SHALL hold their values unchanged.
REQ-025 When there is no stall and no accept, fetch_valid SHALL be 0 on the next cycle.
REQ-026 A fetch with fetch_addr[1:0]!=0 or fetch_addr>=4*DEPTH SHALL return FILL_WORD with fetch_err=1, alongside fetch_valid.
REQ-027 In RUN, ld_en with an aligned, in-range ld_addr SHALL write ld_data; ld_ack pulses on the next cycle.
REQ-028 A misaligned or out-of-range load SHALL be discarded with no ack.
REQ-029 A load and a fetch to the same word in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-030 On rst, the FSM SHALL enter INIT, the fill counter SHALL be 0, and all outputs SHALL be 0.
REQ-031 An rst asserted mid-fill or mid-fetch SHALL abort the current operation and restart the full fill.

Configuration
REQ-032 With IMEM_PARITY_EN defined:
- each word SHALL store one extra even-parity bit;
- a fetch whose parity mismatches SHALL set parity_err=1 with fetch_valid;
- an added input ld_par_inv (1 bit) SHALL invert the stored parity bit on a load.
REQ-033 Without IMEM_PARITY_EN, there SHALL be no parity storage, parity_err SHALL be tied to 0, and ld_par_inv SHALL be absent.

Structure
REQ-034 Package imem_pkg SHALL hold the FSM state enum, the default FILL_WORD constant, and the parity function.
REQ-035 Storage SHALL be the sub-module imem_array: one synchronous read port and one write port, width DATA_W (+1 with parity).

Verification
REQ-036 Scenario: release rst, DEPTH=64.
- init_done rises on cycle 64.
- A fetch of 0x00 returns 0xFFFFFFFF with fetch_err=0.
REQ-037 Scenario: load 0x24010148 to 0x10, then fetch 0x10.
- ld_ack pulses once.
- fetch_word=0x24010148 one cycle after the accept.
REQ-038 Scenario: fetch 0x12, then fetch 0x100 with DEPTH=64.
- Both return 0xFFFFFFFF with fetch_err=1.
REQ-039 Scenario: assert fetch_stall for 3 cycles while fetch_valid=1.
- fetch_word is held.
- fetch_ready=0 throughout.
- A new request is accepted on the cycle stall drops.
REQ-040 Scenario: in the same cycle, load 0x0800002C to 0x08 and fetch 0x08.
- The first fetch returns the old word.
- A repeat fetch returns 0x0800002C.
REQ-041 Scenario: rst pulse at fill count 20.
- init_done rises 64 cycles after release.
- With IMEM_PARITY_EN, a load with ld_par_inv=1 followed by a fetch gives parity_err=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction memory: controller
// states, the default fill pattern and the parity helper.
package imem_pkg;

  // Widest instruction word the shared helpers below support
  localparam int unsigned MAX_DATA_W = 256;

  // Default init / error word: all ones, sliced down to the instance width
  localparam logic [MAX_DATA_W-1:0] DEFAULT_FILL_WORD = '1;

  // Controller phases: fill every word, then serve fetches and loads
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Even parity over a zero-extended word; the extension does not change it
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word storage for imem_sync: one synchronous read port and one write port.
// A read and a write to the same word in one cycle return the old contents.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read share an edge, so a same-word read sees old data
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory with a fill-on-reset controller, a stallable
// single-cycle-latency fetch port and a program-load write port.
// Optional feature: define IMEM_PARITY_EN to store one even-parity bit per word,
// flag mismatches on parity_err and add the ld_par_inv input.
module imem_sync
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DEFAULT_FILL_WORD[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_word,
  output logic              fetch_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
`ifdef IMEM_PARITY_EN
  input  logic              ld_par_inv,
`endif
  output logic              ld_ack,
  output logic              init_done,
  output logic              parity_err
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  state_t            state;
  logic [AW-1:0]     fill_cnt;
  logic              fetch_bad;
  logic              ld_ok;
  logic              hold;
  logic              accept;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;
  logic [MEM_W-1:0]  fill_entry;
  logic [MEM_W-1:0]  ld_entry;

  // An address is usable only if word aligned and below 4*DEPTH bytes
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (AW + 2)) != '0);
  assign ld_ok     = (ld_addr[1:0] == 2'b00) && ((ld_addr >> (AW + 2)) == '0);

  // A valid word under stall is frozen, so no new request can be taken
  assign hold        = fetch_valid & fetch_stall;
  assign fetch_ready = (state == RUN) & ~hold;
  assign accept      = fetch_req & fetch_ready;

`ifdef IMEM_PARITY_EN
  assign fill_entry = {calc_parity(MAX_DATA_W'(FILL_WORD)), FILL_WORD};
  assign ld_entry   = {calc_parity(MAX_DATA_W'(ld_data)) ^ ld_par_inv, ld_data};
`else
  assign fill_entry = FILL_WORD;
  assign ld_entry   = ld_data;
`endif

  // Write port belongs to the fill counter in INIT and to valid loads in RUN
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = fill_cnt;
      mem_wdata = fill_entry;
    end else if (ld_en && ld_ok) begin
      mem_we    = 1'b1;
      mem_waddr = ld_addr[AW+1:2];
      mem_wdata = ld_entry;
    end
  end

  imem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (accept),
    .raddr (fetch_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

  // Bad fetches report the fill word; the read register holds under stall
  assign fetch_word = !fetch_valid ? '0 :
                      fetch_err    ? FILL_WORD : mem_rdata[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
  assign parity_err = fetch_valid & ~fetch_err &
                      (calc_parity(MAX_DATA_W'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
`else
  assign parity_err = 1'b0;
`endif

  // Controller: fill all words after reset, then track fetch and load status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      fill_cnt    <= '0;
      init_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      ld_ack      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          fill_cnt    <= fill_cnt + AW'(1);
          fetch_valid <= 1'b0;
          fetch_err   <= 1'b0;
          ld_ack      <= 1'b0;
          if (fill_cnt == AW'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            fetch_valid <= 1'b1;
            fetch_err   <= fetch_bad;
          end else if (!hold) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
          end
          ld_ack <= ld_en & ld_ok;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// word-array model of the memory.
module tb_imem_sync;

  localparam int DEPTH = 64;
  localparam logic [31:0] FILL = 32'hFFFF_FFFF;
`ifdef IMEM_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchStall;
  logic        fetchReady;
  logic        fetchValid;
  logic [31:0] fetchWord;
  logic        fetchErr;
  logic        ldEn;
  logic [31:0] ldAddr;
  logic [31:0] ldData;
  logic        ldParInv;
  logic        ldAck;
  logic        initDone;
  logic        parityErr;

  int tests;
  int failures;
  bit checkEn;

  // Reference model: memory contents plus the expected output status
  logic [31:0] mMem [DEPTH];
  bit          mParBad [DEPTH];
  int          mFillCount;
  bit          mInit;
  bit          mValid;
  bit          mErr;
  bit          mAck;
  bit          mPerr;
  logic [31:0] mWord;

  imem_sync #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetchReq),
    .fetch_addr  (fetchAddr),
    .fetch_stall (fetchStall),
    .fetch_ready (fetchReady),
    .fetch_valid (fetchValid),
    .fetch_word  (fetchWord),
    .fetch_err   (fetchErr),
    .ld_en       (ldEn),
    .ld_addr     (ldAddr),
    .ld_data     (ldData),
`ifdef IMEM_PARITY_EN
    .ld_par_inv  (ldParInv),
`endif
    .ld_ack      (ldAck),
    .init_done   (initDone),
    .parity_err  (parityErr)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addrBad(input logic [31:0] a);
    logic [1:0] low;
    low = a[1:0];
    return (low != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  task automatic modelReset();
    mInit      = 1'b1;
    mFillCount = 0;
    mValid     = 1'b0;
    mErr       = 1'b0;
    mAck       = 1'b0;
    mPerr      = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT just sampled
  task automatic modelStep();
    bit hold;
    bit bad;
    int idx;
    if (rst) return;
    if (mInit) begin
      mFillCount++;
      mValid = 1'b0;
      mErr   = 1'b0;
      mAck   = 1'b0;
      mPerr  = 1'b0;
      if (mFillCount == DEPTH) begin
        mInit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          mMem[i]    = FILL;
          mParBad[i] = 1'b0;
        end
      end
      return;
    end
    hold = mValid && fetchStall;
    if (fetchReq && !hold) begin
      bad    = addrBad(fetchAddr);
      mValid = 1'b1;
      mErr   = bad;
      if (bad) begin
        mWord = FILL;
        mPerr = 1'b0;
      end else begin
        idx   = int'(fetchAddr >> 2);
        mWord = mMem[idx];
        mPerr = mParBad[idx];
      end
    end else if (!hold) begin
      mValid = 1'b0;
      mErr   = 1'b0;
      mPerr  = 1'b0;
    end
    mAck = ldEn && !addrBad(ldAddr);
    if (mAck) begin
      idx          = int'(ldAddr >> 2);
      mMem[idx]    = ldData;
      mParBad[idx] = PARITY_ON && ldParInv;
    end
  endtask

  task automatic checkOutput();
    expectEq("ready", 32'(fetchReady), 32'(!mInit && !(mValid && fetchStall)));
    expectEq("valid", 32'(fetchValid), 32'(mValid));
    if (mValid) expectEq("word", fetchWord, mWord);
    expectEq("err", 32'(fetchErr), 32'(mErr));
    expectEq("ld_ack", 32'(ldAck), 32'(mAck));
    expectEq("init_done", 32'(initDone), 32'(!mInit));
    expectEq("parity_err", 32'(parityErr), 32'(mPerr));
  endtask

  // Compare DUT against the model on every falling edge, away from the active edge
  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit req, input logic [31:0] addr, input bit stall,
                               input bit ld, input logic [31:0] la, input logic [31:0] ldv,
                               input bit inv);
    fetchReq   = req;
    fetchAddr  = addr;
    fetchStall = stall;
    ldEn       = ld;
    ldAddr     = la;
    ldData     = ldv;
    ldParInv   = inv;
  endtask

  task automatic checkResetOutputs(input string tag);
    expectEq({tag, "_ready"}, 32'(fetchReady), 32'd0);
    expectEq({tag, "_valid"}, 32'(fetchValid), 32'd0);
    expectEq({tag, "_word"}, fetchWord, 32'd0);
    expectEq({tag, "_err"}, 32'(fetchErr), 32'd0);
    expectEq({tag, "_ack"}, 32'(ldAck), 32'd0);
    expectEq({tag, "_init_done"}, 32'(initDone), 32'd0);
    expectEq({tag, "_parity_err"}, 32'(parityErr), 32'd0);
  endtask

  task automatic waitInit(input string tag);
    int n;
    n = 0;
    while (!initDone && n < 200) begin
      tick();
      n++;
    end
    expectEq({tag, "_cycles"}, 32'(n), 32'd64);
  endtask

  function automatic logic [31:0] randAddr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 12) return 32'($urandom_range(0, 15)) << 2;
    if (r == 12) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r == 13) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    if (r == 14) return 32'(4 * DEPTH) + (32'($urandom_range(0, 255)) << 2);
    return $urandom;
  endfunction

  task automatic pulseReset(input int holdCycles);
    rst = 1'b1;
    modelReset();
    #1;
    checkResetOutputs("rst");
    repeat (holdCycles) tick();
    rst = 1'b0;
  endtask

  // Bound the whole run in case the DUT never reaches a waited-for state
  initial begin
    #400000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    tests    = 0;
    failures = 0;
    checkEn  = 1'b0;
    rst      = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    modelReset();
    @(negedge clk);
    #1;
    checkEn = 1'b1;
    checkResetOutputs("por");
    rst = 1'b0;
    waitInit("init");

    // Fetch of an untouched word returns the fill pattern
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("fill_valid", 32'(fetchValid), 32'd1);
    expectEq("fill_word", fetchWord, 32'hFFFF_FFFF);
    expectEq("fill_err", 32'(fetchErr), 32'd0);

    // Program load then fetch back
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h2401_0148, 1'b0);
    tick();
    expectEq("load_ack", 32'(ldAck), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("load_ack_once", 32'(ldAck), 32'd0);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("load_word", fetchWord, 32'h2401_0148);
    expectEq("model_load_word", mWord, 32'h2401_0148);

    // Misaligned and out-of-range fetches
    applyStimulus(1'b1, 32'h12, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("misalign_word", fetchWord, 32'hFFFF_FFFF);
    expectEq("misalign_err", 32'(fetchErr), 32'd1);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("range_word", fetchWord, 32'hFFFF_FFFF);
    expectEq("range_err", 32'(fetchErr), 32'd1);
    expectEq("model_range_err", 32'(mErr), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("idle_valid", 32'(fetchValid), 32'd0);

    // Stall holds the word for three cycles, then the next request goes in
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectEq("stall_word", fetchWord, 32'h2401_0148);
      expectEq("stall_valid", 32'(fetchValid), 32'd1);
      expectEq("stall_ready", 32'(fetchReady), 32'd0);
    end
    applyStimulus(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    expectEq("unstall_ready", 32'(fetchReady), 32'd1);
    tick();
    expectEq("unstall_word", fetchWord, 32'hFFFF_FFFF);
    expectEq("unstall_valid", 32'(fetchValid), 32'd1);

    // Same-cycle load and fetch: old data first, new data on repeat
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b1, 32'h08, 32'h0800_002C, 1'b0);
    tick();
    expectEq("rbw_old", fetchWord, 32'hFFFF_FFFF);
    expectEq("rbw_ack", 32'(ldAck), 32'd1);
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("rbw_new", fetchWord, 32'h0800_002C);

    // Reset part-way through a fill restarts the whole fill
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    pulseReset(1);
    repeat (20) tick();
    expectEq("midfill_init_done", 32'(initDone), 32'd0);
    pulseReset(1);
    waitInit("refill");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("refill_word", fetchWord, 32'hFFFF_FFFF);

`ifdef IMEM_PARITY_EN
    // Deliberately corrupted parity is reported on fetch
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("par_word", fetchWord, 32'h1234_5678);
    expectEq("par_err", 32'(parityErr), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    expectEq("par_clean", 32'(parityErr), 32'd0);
`endif

    // Randomized traffic, with occasional resets, checked by the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulseReset(int'($urandom_range(1, 3)));
      end
      applyStimulus($urandom_range(0, 3) != 0, randAddr(), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, randAddr(), $urandom,
                    $urandom_range(0, 7) == 0);
      tick();
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
